// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types.
// Used by the register file and its write-back stage.
package cpu_pkg;

    localparam int REG_WIDTH  = 8;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;

    // Simulation-only timing of the original model, in time units.
    localparam int READ_DELAY  = 2;
    localparam int WRITE_DELAY = 1;

    typedef enum logic [2:0] {
        ALU_FORWARD = 3'b000,
        ALU_ADD     = 3'b001,
        ALU_AND     = 3'b010,
        ALU_OR      = 3'b011
    } alu_sel_e;

endpackage

// File: rtl/wb_stage.sv
// One-entry write-back capture register for the register file.
// Holds the ALU result for one cycle before it commits to the array.
module wb_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH  = REG_WIDTH,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              wb_valid,
    output logic [WIDTH-1:0]  wb_data,
    output logic [ADDR_W-1:0] wb_addr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_addr  <= '0;
        end else begin
            wb_valid <= write;
            if (write) begin
                wb_data <= in_data;
                wb_addr <= in_addr;
            end
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// 8x8 register file: two forwarding read ports, one write port
// fed through a single-entry write-back stage.
module reg_file_wb
    import cpu_pkg::*;
#(
    parameter int WIDTH    = REG_WIDTH,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS,
    parameter int ADDR_W   = REG_ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [WIDTH-1:0]  IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [WIDTH-1:0]  OUT1,
    output logic [WIDTH-1:0]  OUT2,
    output logic              WB_PENDING
);

    logic              wb_valid;
    logic [WIDTH-1:0]  wb_data;
    logic [ADDR_W-1:0] wb_addr;
    logic [WIDTH-1:0]  regs [NUM_REGS];

    wb_stage #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_wb_stage (
        .clk      (CLK),
        .rst_n    (RESET),
        .write    (WRITE),
        .in_data  (IN),
        .in_addr  (INADDRESS),
        .wb_valid (wb_valid),
        .wb_data  (wb_data),
        .wb_addr  (wb_addr)
    );

    // Commit of the pending entry shares the edge with the next capture.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign OUT1 = (wb_valid && wb_addr == OUT1ADDRESS) ? wb_data
                                                        : regs[OUT1ADDRESS];
    assign OUT2 = (wb_valid && wb_addr == OUT2ADDRESS) ? wb_data
                                                        : regs[OUT2ADDRESS];

    assign WB_PENDING = wb_valid;

endmodule
